kpn_channel_arbiter: RTL and testbench

- Shares the write side of one KPN channel FIFO (16-bit tokens, 2**5 entries) among N_REQ producer processes.
- Round-robin grant, one producer owns the channel per burst; burst ends on producer's last flag, MAX_BURST words, or req withdrawal.
- Sits between KPN process nodes and the queue module's write port; honours the queue's full flag.

---
 rtl/kpn_arb_pkg.sv | 20 ++
 rtl/kpn_rr_pick.sv | 32 +++
 rtl/kpn_channel_arbiter.sv | 148 ++++++++++++++
 tb/tb_kpn_channel_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kpn_arb_pkg.sv
// Shared types and helpers for the KPN channel write-side arbiter.
// Optional per-producer statistics are enabled with KPN_ARB_STATS_EN.
package kpn_arb_pkg;

    localparam int BITS_NUMBER_DEF = 16;
    localparam int STAT_WIDTH      = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } kpn_arb_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/kpn_rr_pick.sv
// Combinational round-robin picker: first asserted req at or after rr_ptr,
// wrapping modulo N_REQ (non-power-of-2 N_REQ supported).
module kpn_rr_pick
    import kpn_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [clog2(N_REQ)-1:0] rr_ptr,
    output logic [N_REQ-1:0]        winner,
    output logic                    valid
);

    localparam int PTR_W = clog2(N_REQ);
    localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(N_REQ);

    always_comb begin
        logic [PTR_W:0] pos;
        winner = '0;
        valid  = 1'b0;
        pos    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (pos >= N_EXT) pos = pos - N_EXT;
            if (!valid && req[pos[PTR_W-1:0]]) begin
                winner[pos[PTR_W-1:0]] = 1'b1;
                valid                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/kpn_channel_arbiter.sv
// Round-robin burst arbiter sharing one KPN channel FIFO write port among
// N_REQ producers. Define KPN_ARB_STATS_EN for per-producer accept counters.
module kpn_channel_arbiter
    import kpn_arb_pkg::*;
#(
    parameter int BITS_NUMBER = BITS_NUMBER_DEF,
    parameter int N_REQ       = 4,
    parameter int MAX_BURST   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ-1:0]              req_last,
    input  logic [N_REQ*BITS_NUMBER-1:0]  req_data,
    output logic [N_REQ-1:0]              ack,
    output logic [N_REQ-1:0]              gnt,
    input  logic                          fifo_full,
    output logic                          fifo_wr,
    output logic [BITS_NUMBER-1:0]        fifo_din,
    output logic                          busy,
`ifdef KPN_ARB_STATS_EN
    input  logic [clog2(N_REQ)-1:0]       stat_sel,
    output logic [STAT_WIDTH-1:0]         stat_count,
`endif
    output kpn_arb_state_e                state_dbg,
    output logic [clog2(N_REQ)-1:0]       rr_ptr_dbg
);

    localparam int PTR_W = clog2(N_REQ);
    localparam int CNT_W = clog2(MAX_BURST + 1);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] BURST_END = CNT_W'(MAX_BURST - 1);

    kpn_arb_state_e         state, state_d;
    logic [N_REQ-1:0]       gnt_d;
    logic                   busy_d, wr_d;
    logic [BITS_NUMBER-1:0] din_d, owner_data;
    logic [PTR_W-1:0]       rr_ptr, rr_d, owner, owner_d, win_idx, next_ptr;
    logic [CNT_W-1:0]       burst_cnt, cnt_d;
    logic [N_REQ-1:0]       win_onehot;
    logic                   win_valid;
    logic                   owner_req, owner_last, accept, rel;

    kpn_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (win_onehot),
        .valid  (win_valid)
    );

    always_comb begin
        win_idx    = '0;
        owner_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_onehot[i]) win_idx = PTR_W'(i);
            if (gnt[i]) owner_data = req_data[i*BITS_NUMBER +: BITS_NUMBER];
        end
    end

    // Handshake: req[i] is valid for the word on slice i; ack[i] is the
    // same-cycle transfer indication (owner, valid and queue not full).
    assign owner_req  = |(req & gnt);
    assign owner_last = |(req_last & gnt);
    assign accept     = (state == GRANT) && owner_req && !fifo_full;
    assign rel        = (state == GRANT) &&
                        (!owner_req || (accept && (owner_last || burst_cnt == BURST_END)));
    assign ack        = gnt & {N_REQ{accept}};
    assign next_ptr   = (owner == LAST_IDX) ? '0 : owner + 1'b1;

    always_comb begin
        state_d = state;
        gnt_d   = gnt;
        busy_d  = busy;
        rr_d    = rr_ptr;
        cnt_d   = burst_cnt;
        owner_d = owner;
        wr_d    = 1'b0;
        din_d   = fifo_din;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_d = GRANT;
                    gnt_d   = win_onehot;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    owner_d = win_idx;
                end
            end
            GRANT: begin
                if (accept) begin
                    wr_d  = 1'b1;
                    din_d = owner_data;
                    cnt_d = burst_cnt + 1'b1;
                end
                if (rel) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    rr_d    = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            busy      <= 1'b0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            owner     <= '0;
            fifo_wr   <= 1'b0;
            fifo_din  <= '0;
        end else begin
            state     <= state_d;
            gnt       <= gnt_d;
            busy      <= busy_d;
            rr_ptr    <= rr_d;
            burst_cnt <= cnt_d;
            owner     <= owner_d;
            fifo_wr   <= wr_d;
            fifo_din  <= din_d;
        end
    end

    assign state_dbg  = state;
    assign rr_ptr_dbg = rr_ptr;

`ifdef KPN_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] stat_cnt [N_REQ];

    // Counters saturate at all-ones; readout is registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) stat_cnt[i] <= '0;
            stat_count <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (ack[i] && stat_cnt[i] != '1) stat_cnt[i] <= stat_cnt[i] + 1'b1;
            end
            stat_count <= (int'(stat_sel) < N_REQ) ? stat_cnt[stat_sel] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_kpn_channel_arbiter.sv
// Directed self-checking bench for kpn_channel_arbiter (N_REQ=4, MAX_BURST=8).
// Statistics checks are built when KPN_ARB_STATS_EN is defined.
module tb_kpn_channel_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  req_last = '0;
    logic [63:0] req_data = '0;
    logic [3:0]  ack;
    logic [3:0]  gnt;
    logic        fifo_full = 1'b0;
    logic        fifo_wr;
    logic [15:0] fifo_din;
    logic        busy;
    logic        state_dbg;
    logic [1:0]  rr_ptr_dbg;
`ifdef KPN_ARB_STATS_EN
    logic [1:0]  stat_sel = '0;
    logic [15:0] stat_count;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    logic [15:0] exp_q[$];
    logic        sb_en = 1'b1;

    kpn_channel_arbiter #(.BITS_NUMBER(16), .N_REQ(4), .MAX_BURST(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_last   (req_last),
        .req_data   (req_data),
        .ack        (ack),
        .gnt        (gnt),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_din   (fifo_din),
        .busy       (busy),
`ifdef KPN_ARB_STATS_EN
        .stat_sel   (stat_sel),
        .stat_count (stat_count),
`endif
        .state_dbg  (state_dbg),
        .rr_ptr_dbg (rr_ptr_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] wd(input logic [15:0] base, input int i);
        return base + 16'(i * 256);
    endfunction

    task automatic set_all(input logic [15:0] base);
        for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = wd(base, i);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every queue write must match the next expected word
    always @(negedge clk) begin
        if (sb_en && fifo_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $error("FAIL sb_unexpected_write observed=0x%0h expected=none", fifo_din);
            end else begin
                check("sb_data", 32'(fifo_din), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        // ---- reset state
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_wr", 32'(fifo_wr), 32'h0);
        check("rst_din", 32'(fifo_din), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_state", 32'(state_dbg), 32'h0);
        check("rst_rr", 32'(rr_ptr_dbg), 32'h0);

        // ---- single producer, last on 3rd word
        rst = 1'b0;
        req = 4'b0001;
        set_all(16'h00A1);
        tick();
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_busy", 32'(busy), 32'h1);
        check("t1_wr_idle", 32'(fifo_wr), 32'h0);
        for (int w = 0; w < 3; w++) begin
            set_all(16'h00A1 + 16'(w));
            req_last = (w == 2) ? 4'b0001 : 4'b0000;
            exp_q.push_back(16'h00A1 + 16'(w));
            #1 check("t1_ack", 32'(ack), 32'h1);
            tick();
            check("t1_wr", 32'(fifo_wr), 32'h1);
            check("t1_din", 32'(fifo_din), 32'h00A1 + 32'(w));
        end
        check("t1_rel_gnt", 32'(gnt), 32'h0);
        check("t1_rel_busy", 32'(busy), 32'h0);
        check("t1_rr", 32'(rr_ptr_dbg), 32'h1);
        req = '0;
        req_last = '0;
        tick();
        check("t1_wr_off", 32'(fifo_wr), 32'h0);
        check("t1_din_hold", 32'(fifo_din), 32'h00A3);

        // ---- all request, max bursts, rotation 0,1,2,3,0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            tick();
            check("t2_gnt", 32'(gnt), 32'(1 << (b % 4)));
            check("t2_wr_idle", 32'(fifo_wr), 32'h0);
            for (int w = 0; w < 8; w++) begin
                set_all(16'h2000 + 16'(b * 16 + w));
                exp_q.push_back(wd(16'h2000 + 16'(b * 16 + w), b % 4));
                #1 check("t2_ack", 32'(ack), 32'(1 << (b % 4)));
                tick();
                check("t2_wr", 32'(fifo_wr), 32'h1);
            end
            check("t2_rel_gnt", 32'(gnt), 32'h0);
            check("t2_rel_busy", 32'(busy), 32'h0);
            check("t2_idle_ack", 32'(ack), 32'h0);
        end
        check("t2_rr", 32'(rr_ptr_dbg), 32'h1);
        req = '0;

        // ---- owner 2 stalled by fifo_full mid-burst; last coincides with max
        req = 4'b0100;
        tick();
        check("t3_gnt", 32'(gnt), 32'h4);
        for (int w = 0; w < 8; w++) begin
            if (w == 2) begin
                fifo_full = 1'b1;
                for (int s = 0; s < 5; s++) begin
                    #1 check("t3_stall_ack", 32'(ack), 32'h0);
                    tick();
                    check("t3_stall_wr", 32'(fifo_wr), 32'h0);
                    check("t3_stall_gnt", 32'(gnt), 32'h4);
                    check("t3_stall_din", 32'(fifo_din), 32'h3201);
                end
                fifo_full = 1'b0;
            end
            set_all(16'h3000 + 16'(w));
            req_last = (w == 7) ? 4'b0100 : 4'b0000;
            exp_q.push_back(wd(16'h3000 + 16'(w), 2));
            #1 check("t3_ack", 32'(ack), 32'h4);
            tick();
            check("t3_gnt_run", 32'(gnt), (w == 7) ? 32'h0 : 32'h4);
        end
        check("t3_rr", 32'(rr_ptr_dbg), 32'h3);
        req = '0;
        req_last = '0;
        tick();
        check("t3_post_gnt", 32'(gnt), 32'h0);
        check("t3_post_state", 32'(state_dbg), 32'h0);
        check("t3_post_wr", 32'(fifo_wr), 32'h0);

        // ---- owner 1 withdraws after 2 words, producer 3 pending
        req = 4'b0010;
        tick();
        check("t4_gnt", 32'(gnt), 32'h2);
        for (int w = 0; w < 2; w++) begin
            set_all(16'h4000 + 16'(w));
            exp_q.push_back(wd(16'h4000 + 16'(w), 1));
            tick();
        end
        req = 4'b1000;
        #1 check("t4_drop_ack", 32'(ack), 32'h0);
        tick();
        check("t4_rel_gnt", 32'(gnt), 32'h0);
        check("t4_rr", 32'(rr_ptr_dbg), 32'h2);
        check("t4_rel_wr", 32'(fifo_wr), 32'h0);
        tick();
        check("t4_gnt3", 32'(gnt), 32'h8);
        req = '0;
        tick();
        check("t4_rr_wrap", 32'(rr_ptr_dbg), 32'h0);

        // ---- reset during 4th cycle of a burst
        req = 4'b0100;
        req_last = 4'b0100;
        set_all(16'h5000);
        tick();
        exp_q.push_back(wd(16'h5000, 2));
        tick();
        check("t5_rr_pre", 32'(rr_ptr_dbg), 32'h3);
        req = 4'b0010;
        req_last = '0;
        tick();
        check("t5_gnt", 32'(gnt), 32'h2);
        for (int w = 0; w < 3; w++) begin
            set_all(16'h6000 + 16'(w));
            exp_q.push_back(wd(16'h6000 + 16'(w), 1));
            tick();
        end
        set_all(16'h6003);
        #1 check("t5_ack4", 32'(ack), 32'h2);
        rst = 1'b1;
        tick();
        check("t5_rst_gnt", 32'(gnt), 32'h0);
        check("t5_rst_wr", 32'(fifo_wr), 32'h0);
        check("t5_rst_busy", 32'(busy), 32'h0);
        check("t5_rst_rr", 32'(rr_ptr_dbg), 32'h0);
        rst = 1'b0;
        req = 4'b1001;
        tick();
        check("t5_gnt0", 32'(gnt), 32'h1);
        req = '0;
        tick();
        check("t5_end_gnt", 32'(gnt), 32'h0);

`ifdef KPN_ARB_STATS_EN
        // ---- statistics
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0010;
        tick();
        for (int w = 0; w < 3; w++) begin
            set_all(16'h7000 + 16'(w));
            req_last = (w == 2) ? 4'b0010 : 4'b0000;
            exp_q.push_back(wd(16'h7000 + 16'(w), 1));
            tick();
        end
        req = '0;
        req_last = '0;
        stat_sel = 2'd1;
        tick();
        tick();
        check("st_count3", 32'(stat_count), 32'h3);
        stat_sel = 2'd0;
        tick();
        check("st_count0", 32'(stat_count), 32'h0);
        sb_en = 1'b0;
        req = 4'b0010;
        repeat (79000) @(posedge clk);
        #1;
        req = '0;
        stat_sel = 2'd1;
        tick();
        tick();
        tick();
        check("st_sat", 32'(stat_count), 32'hFFFF);
`endif

        tick();
        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
